// File: rtl/sram_mem_controller.sv
// sram_mem_controller: MEM-stage bridge that splits each 32-bit load/store
// into two 16-bit accesses (low halfword, then high) on an asynchronous SRAM,
// holding each phase for WAIT_CYCLES+1 clocks and freezing the pipeline
// through ready while the access is in flight.
module sram_mem_controller #(
   parameter logic [31:0] ADDR_BASE   = 32'd1024,
   parameter int          SRAM_AW     = 18,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               wr_op_q, wr_op_d;
   logic [SRAM_AW-2:0] word_q, word_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;

   logic [31:0]        offset;
   logic               req;
   logic               phase_last;
   logic               unused_addr_bits;

   // Byte offset into the SRAM window; high bits and the byte lane are dropped,
   // so out-of-window addresses wrap silently.
   assign offset           = address - ADDR_BASE;
   assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
   assign req              = rd_en | wr_en;
   assign phase_last       = (cnt_q == WAIT_LAST);
   assign read_data        = rdata_q;

   // Control state, latched word index and load result (async reset).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_op_q <= 1'b0;
         word_q  <= '0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_op_q <= wr_op_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
      end
   end

   // Store data is only consumed while the latched op is a write, so it needs no reset.
   always_ff @(posedge clk) begin
      wdata_q <= wdata_d;
   end

   // Next-state logic and Moore decode of the SRAM strobes from registered state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_op_d     = wr_op_q;
      word_d      = word_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      ready       = 1'b0;
      sram_ce_n   = 1'b1;
      sram_oe_n   = 1'b1;
      sram_we_n   = 1'b1;
      sram_dq_oe  = 1'b0;
      sram_dq_out = 16'h0000;
      sram_addr   = {word_q, (state_q == HI)};

      case (state_q)
         IDLE: begin
            ready = ~req;
            if (req) begin
               // A simultaneous load and store resolves to the store.
               wr_op_d = wr_en;
               word_d  = offset[SRAM_AW:2];
               wdata_d = write_data;
               cnt_d   = 4'd0;
               state_d = LO;
            end
         end
         LO: begin
            sram_ce_n = 1'b0;
            if (wr_op_q) begin
               sram_we_n   = 1'b0;
               sram_dq_oe  = 1'b1;
               sram_dq_out = wdata_q[15:0];
            end else begin
               sram_oe_n = 1'b0;
            end
            if (phase_last) begin
               if (!wr_op_q) begin
                  rdata_d[15:0] = sram_dq_in;
               end
               cnt_d   = 4'd0;
               state_d = HI;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HI: begin
            sram_ce_n = 1'b0;
            if (wr_op_q) begin
               sram_we_n   = 1'b0;
               sram_dq_oe  = 1'b1;
               sram_dq_out = wdata_q[31:16];
            end else begin
               sram_oe_n = 1'b0;
            end
            if (phase_last) begin
               if (!wr_op_q) begin
                  rdata_d[31:16] = sram_dq_in;
               end
               cnt_d   = 4'd0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            // Pipeline advances on this edge; any request seen now is the next one.
            ready   = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
